// File: rtl/glitch_wb_mq.sv
// Multi-channel Wishbone slave assembling glitch-queue words from lane writes into per-channel FIFOs.
// Optional per-channel push counters are enabled by defining GLITCH_WB_COUNT_EN.
module glitch_wb_mq #(
  parameter int DAT_W     = 8,
  parameter int WORD_W    = 32,
  parameter int NCH       = 2,
  parameter int STALL_MAX = 16,
  localparam int ADR_W    = 4 + $clog2(NCH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADR_W-1:0]      adr_i,
  input  logic [DAT_W-1:0]      dat_i,
  output logic [DAT_W-1:0]      dat_o,
  input  logic                  we_i,
  input  logic                  stb_i,
  output logic                  ack_o,
  output logic [NCH*WORD_W-1:0] q_data_o,
  output logic [NCH-1:0]        q_we_o,
  input  logic [NCH-1:0]        q_full_i,
  input  logic [NCH-1:0]        q_empty_i,
  input  logic [NCH-1:0]        ready_i
);

  localparam int LANES = WORD_W / DAT_W;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SC_W  = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]        r_state;
  logic              r_ack;
  logic [DAT_W-1:0]  r_dat;
  logic [NCH-1:0]    r_q_we;
  logic [NCH-1:0]    r_ovf;
  logic [SC_W-1:0]   r_sc;
  logic [WORD_W-1:0] r_pend_word;
  logic [CH_W-1:0]   r_pend_ch;
  logic [WORD_W-1:0] r_stage  [NCH];
  logic [WORD_W-1:0] r_q_data [NCH];
`ifdef GLITCH_WB_COUNT_EN
  logic [2*DAT_W-1:0] r_cnt   [NCH];
`endif

  logic [7:0]        w_adr_ext;
  logic [3:0]        w_ch;
  logic [3:0]        w_reg;
  logic [2:0]        w_lane;
  logic [CH_W-1:0]   w_ci;
  logic              w_ch_ok;
  logic              w_is_lane;
  logic              w_is_commit;
  logic [DAT_W-1:0]  w_rdata;
  logic [WORD_W-1:0] w_push_word;

  // Address split: channel above bit 4, register in the low nibble
  assign w_adr_ext   = 8'(adr_i);
  assign w_ch        = w_adr_ext[7:4];
  assign w_reg       = w_adr_ext[3:0];
  assign w_lane      = w_reg[2:0];
  assign w_ci        = w_ch[CH_W-1:0];
  assign w_ch_ok     = ({28'd0, w_ch} < NCH);
  assign w_is_lane   = w_reg[3] && ({29'd0, w_lane} < LANES);
  assign w_is_commit = (w_reg == 4'(8 + LANES - 1));

  always_comb begin
    w_rdata = '0;
    if (w_ch_ok) begin
      case (w_reg)
        4'd0: w_rdata = DAT_W'({r_ovf[w_ci], q_full_i[w_ci], q_empty_i[w_ci], ready_i[w_ci]});
`ifdef GLITCH_WB_COUNT_EN
        4'd2: w_rdata = r_cnt[w_ci][DAT_W-1:0];
        4'd3: w_rdata = r_cnt[w_ci][2*DAT_W-1:DAT_W];
`endif
        default: begin
          if (w_is_lane) w_rdata = r_stage[w_ci][w_lane*DAT_W +: DAT_W];
        end
      endcase
    end
  end

  // The pushed word is the stage with its top lane replaced by the committing write
  always_comb begin
    w_push_word = r_stage[w_ci];
    w_push_word[(LANES-1)*DAT_W +: DAT_W] = dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_q_we      <= '0;
      r_ovf       <= '0;
      r_sc        <= '0;
      r_pend_word <= '0;
      r_pend_ch   <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_stage[c]  <= '0;
        r_q_data[c] <= '0;
`ifdef GLITCH_WB_COUNT_EN
        r_cnt[c]    <= '0;
`endif
      end
    end else begin
      r_q_we <= '0;
      r_ack  <= 1'b0;
      r_dat  <= '0;
      case (r_state)
        S_IDLE: begin
          if (stb_i && !r_ack) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
            if (!we_i) begin
              r_dat <= w_rdata;
            end else if (w_ch_ok) begin
              if (w_is_lane) r_stage[w_ci][w_lane*DAT_W +: DAT_W] <= dat_i;
              if (w_reg == 4'd1) begin
                if (dat_i[0]) r_ovf[w_ci] <= 1'b0;
                if (dat_i[1]) r_stage[w_ci] <= '0;
              end
`ifdef GLITCH_WB_COUNT_EN
              if (w_reg == 4'd2) r_cnt[w_ci] <= '0;
`endif
              if (w_is_commit) begin
                if (!q_full_i[w_ci]) begin
                  r_q_we[w_ci]   <= 1'b1;
                  r_q_data[w_ci] <= w_push_word;
`ifdef GLITCH_WB_COUNT_EN
                  r_cnt[w_ci]    <= r_cnt[w_ci] + 1'b1;
`endif
                end else if (STALL_MAX == 0) begin
                  r_ovf[w_ci] <= 1'b1;
                end else begin
                  // Hold the ack back until the FIFO drains or the wait budget runs out
                  r_ack       <= 1'b0;
                  r_state     <= S_STALL;
                  r_sc        <= '0;
                  r_pend_word <= w_push_word;
                  r_pend_ch   <= w_ci;
                end
              end
            end
          end
        end
        S_STALL: begin
          if (!q_full_i[r_pend_ch]) begin
            r_q_we[r_pend_ch]   <= 1'b1;
            r_q_data[r_pend_ch] <= r_pend_word;
`ifdef GLITCH_WB_COUNT_EN
            r_cnt[r_pend_ch]    <= r_cnt[r_pend_ch] + 1'b1;
`endif
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else if (r_sc == SC_W'(STALL_MAX - 1)) begin
            r_ovf[r_pend_ch] <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_sc <= r_sc + 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign dat_o  = r_dat;
  assign q_we_o = r_q_we;

  for (genvar g = 0; g < NCH; g++) begin : g_qdata
    assign q_data_o[g*WORD_W +: WORD_W] = r_q_data[g];
  end

endmodule

// File: tb/tb_glitch_wb_mq.sv
// Directed bench for glitch_wb_mq at default parameters; COUNT expectations follow GLITCH_WB_COUNT_EN.
module tb_glitch_wb_mq;

  logic        clk;
  logic        rst_i;
  logic [4:0]  adr_i;
  logic [7:0]  dat_i;
  logic [7:0]  dat_o;
  logic        we_i;
  logic        stb_i;
  logic        ack_o;
  logic [63:0] q_data_o;
  logic [1:0]  q_we_o;
  logic [1:0]  q_full_i;
  logic [1:0]  q_empty_i;
  logic [1:0]  ready_i;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push0 = 0;
  int n_push1 = 0;

`ifdef GLITCH_WB_COUNT_EN
  localparam logic [7:0] EXP_CLO = 8'h01;
  localparam logic [7:0] EXP_CHI = 8'h01;
`else
  localparam logic [7:0] EXP_CLO = 8'h00;
  localparam logic [7:0] EXP_CHI = 8'h00;
`endif

  glitch_wb_mq dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .we_i      (we_i),
    .stb_i     (stb_i),
    .ack_o     (ack_o),
    .q_data_o  (q_data_o),
    .q_we_o    (q_we_o),
    .q_full_i  (q_full_i),
    .q_empty_i (q_empty_i),
    .ready_i   (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (q_we_o[0]) n_push0++;
    if (q_we_o[1]) n_push1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus access; returns read data, wait count and the push outputs seen with ack
  task automatic wb(input logic [4:0] a, input logic w, input logic [7:0] d,
                    output logic [7:0] rd, output int lat,
                    output logic [1:0] we_seen, output logic [63:0] qd_seen);
    adr_i = a; we_i = w; dat_i = d; stb_i = 1'b1;
    lat = 0; rd = '0; we_seen = '0; qd_seen = '0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack_o && lat < 40);
    chk("ack_seen", {63'd0, ack_o}, 64'd1);
    rd = dat_o; we_seen = q_we_o; qd_seen = q_data_o;
    stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0]  rd;
  int          lat;
  logic [1:0]  wes;
  logic [63:0] qds;
  int          p0, p1;

  initial begin
    rst_i = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0;
    q_full_i = '0; q_empty_i = '0; ready_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_ack", {63'd0, ack_o}, 64'd0);
    chk("rst_dat", {56'd0, dat_o}, 64'd0);
    chk("rst_qwe", {62'd0, q_we_o}, 64'd0);
    chk("rst_qdata", q_data_o, 64'd0);

    // Channel 1 assembly and commit
    wb(5'h18, 1'b1, 8'h11, rd, lat, wes, qds);
    chk("lane_lat", lat, 1);
    chk("lane_rd_zero", {56'd0, rd}, 64'd0);
    wb(5'h19, 1'b1, 8'h22, rd, lat, wes, qds);
    wb(5'h1A, 1'b1, 8'h33, rd, lat, wes, qds);
    wb(5'h1B, 1'b1, 8'h44, rd, lat, wes, qds);
    chk("c1_lat", lat, 1);
    chk("c1_we", {62'd0, wes}, 64'd2);
    chk("c1_data", qds, 64'h44332211_00000000);
    chk("c1_push1", n_push1, 1);
    chk("c1_push0", n_push0, 0);

    ready_i = 2'b10; q_empty_i = 2'b10;
    wb(5'h10, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("c1_status", {56'd0, rd}, 64'h03);
    ready_i = 2'b00; q_empty_i = 2'b00;

    // Channel 0 commit stalled for five full samples
    wb(5'h08, 1'b1, 8'h01, rd, lat, wes, qds);
    wb(5'h09, 1'b1, 8'h02, rd, lat, wes, qds);
    wb(5'h0A, 1'b1, 8'h03, rd, lat, wes, qds);
    q_full_i[0] = 1'b1;
    fork
      wb(5'h0B, 1'b1, 8'h04, rd, lat, wes, qds);
      begin repeat (5) @(posedge clk); #1 q_full_i[0] = 1'b0; end
    join
    chk("st5_lat", lat, 6);
    chk("st5_we", {62'd0, wes}, 64'd1);
    chk("st5_data", qds, 64'h44332211_04030201);
    chk("st5_push0", n_push0, 1);
    wb(5'h00, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("st5_status", {56'd0, rd}, 64'h00);

    // Commit against a FIFO that never drains
    q_full_i[0] = 1'b1;
    wb(5'h0B, 1'b1, 8'hEE, rd, lat, wes, qds);
    chk("to_lat", lat, 17);
    chk("to_we", {62'd0, wes}, 64'd0);
    chk("to_push0", n_push0, 1);
    chk("to_data_hold", q_data_o, 64'h44332211_04030201);
    q_full_i[0] = 1'b0;
    wb(5'h00, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("to_status_ovf", {56'd0, rd}, 64'h08);
    wb(5'h01, 1'b1, 8'h01, rd, lat, wes, qds);
    wb(5'h00, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("ovf_cleared", {56'd0, rd}, 64'h00);

    // Lane readback, stage clear, unmapped register
    wb(5'h09, 1'b1, 8'hA5, rd, lat, wes, qds);
    wb(5'h09, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("lane_rb", {56'd0, rd}, 64'hA5);
    wb(5'h0B, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("lane3_rb", {56'd0, rd}, 64'hEE);
    wb(5'h01, 1'b1, 8'h02, rd, lat, wes, qds);
    wb(5'h09, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("clr_lane1", {56'd0, rd}, 64'h00);
    wb(5'h0B, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("clr_lane3", {56'd0, rd}, 64'h00);
    wb(5'h01, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("ctrl_rd0", {56'd0, rd}, 64'h00);
    wb(5'h05, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("unmap_rd", {56'd0, rd}, 64'h00);
    chk("unmap_lat", lat, 1);

    // Push counter on channel 1
    wb(5'h12, 1'b1, 8'h00, rd, lat, wes, qds);
    p1 = n_push1;
    for (int i = 0; i < 257; i++) wb(5'h1B, 1'b1, 8'(i), rd, lat, wes, qds);
    chk("cnt_pushes", n_push1 - p1, 257);
    wb(5'h12, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("cnt_lo", {56'd0, rd}, {56'd0, EXP_CLO});
    wb(5'h13, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("cnt_hi", {56'd0, rd}, {56'd0, EXP_CHI});
    wb(5'h12, 1'b1, 8'h5A, rd, lat, wes, qds);
    wb(5'h12, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("cnt_lo_clr", {56'd0, rd}, 64'h00);
    wb(5'h13, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("cnt_hi_clr", {56'd0, rd}, 64'h00);

    // Reset while stalled
    p0 = n_push0;
    q_full_i[0] = 1'b1;
    adr_i = 5'h0B; we_i = 1'b1; dat_i = 8'h55; stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_no_ack", {63'd0, ack_o}, 64'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ack", {63'd0, ack_o}, 64'd0);
    chk("mrst_qwe", {62'd0, q_we_o}, 64'd0);
    chk("mrst_qdata", q_data_o, 64'd0);
    rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; q_full_i = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_push0", n_push0, p0);
    wb(5'h00, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("mrst_status", {56'd0, rd}, 64'h00);
    chk("mrst_lat", lat, 1);
    wb(5'h08, 1'b1, 8'h5A, rd, lat, wes, qds);
    wb(5'h08, 1'b0, 8'h00, rd, lat, wes, qds);
    chk("mrst_lane_rb", {56'd0, rd}, 64'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
